// File: rtl/mmio_bus_bridge.sv
// Memory/IO bridge behind the bus processor: word RAM, output FIFO, status and LED registers, host load port.
// Optional free-running cycle counter at STATUS_ADDR+1 when MMIO_CYCLE_CNT_EN is defined.
module mmio_bus_bridge #(
  parameter int          MEM_DEPTH   = 256,
  parameter int          FIFO_DEPTH  = 8,
  parameter logic [31:0] FIFO_ADDR   = 32'h0000_1000,
  parameter logic [31:0] STATUS_ADDR = 32'h0000_1001,
  parameter logic [31:0] LED_ADDR    = 32'h0000_2000
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [31:0] proc_addr,
  input  logic [31:0] proc_dout,
  input  logic        proc_w,
  output logic [31:0] proc_din,
  input  logic        load_en,
  input  logic [31:0] load_addr,
  input  logic [31:0] load_data,
  input  logic        host_pop,
  output logic [31:0] host_data,
  output logic        host_valid,
  output logic        fifo_full,
  output logic [31:0] led,
  output logic        bus_err
);
  localparam int AW = $clog2(MEM_DEPTH);
  localparam int FW = $clog2(FIFO_DEPTH);
  localparam int CW = FW + 1;
  localparam logic [31:0] MEM_DEPTH_W = 32'(MEM_DEPTH);

  logic [31:0]   mem      [MEM_DEPTH];
  logic [31:0]   fifo_mem [FIFO_DEPTH];
  logic [FW-1:0] wr_ptr, rd_ptr;
  logic [CW-1:0] count;
  logic          overflow;

  logic        hit_ram, hit_fifo, hit_status, hit_led, hit_cnt, unmapped;
  logic        fifo_empty, pop_fire, push_req, push_fire, overflow_set, load_ok;
  logic [31:0] fifo_head, status_word, rd_data;

`ifdef MMIO_CYCLE_CNT_EN
  logic [31:0] cycle_cnt;
  assign hit_cnt = (proc_addr == STATUS_ADDR + 32'd1);
`else
  assign hit_cnt = 1'b0;
`endif

  assign hit_ram    = (proc_addr < MEM_DEPTH_W);
  assign hit_fifo   = (proc_addr == FIFO_ADDR);
  assign hit_status = (proc_addr == STATUS_ADDR);
  assign hit_led    = (proc_addr == LED_ADDR);
  assign unmapped   = !(hit_ram || hit_fifo || hit_status || hit_led || hit_cnt);
  assign load_ok    = load_en && (load_addr < MEM_DEPTH_W);

  assign fifo_empty = (count == '0);
  assign fifo_full  = (count == CW'(FIFO_DEPTH));
  assign host_valid = !fifo_empty;
  assign fifo_head  = fifo_empty ? 32'd0 : fifo_mem[rd_ptr];
  assign host_data  = fifo_head;

  // A full FIFO still accepts a push when the head leaves in the same cycle.
  assign pop_fire     = host_pop && !fifo_empty;
  assign push_req     = proc_w && hit_fifo;
  assign push_fire    = push_req && (!fifo_full || pop_fire);
  assign overflow_set = push_req && fifo_full && !pop_fire;

  assign status_word = {16'b0, 8'(count), 5'b0, overflow, fifo_full, fifo_empty};

  always_comb begin
    rd_data = 32'd0;
    if (hit_ram)         rd_data = mem[proc_addr[AW-1:0]];
    else if (hit_fifo)   rd_data = fifo_head;
    else if (hit_status) rd_data = status_word;
    else if (hit_led)    rd_data = led;
`ifdef MMIO_CYCLE_CNT_EN
    else if (hit_cnt)    rd_data = cycle_cnt;
`endif
  end

  // Storage arrays carry no reset; host load wins over a same-cycle processor write.
  always_ff @(posedge clk) begin
    if (load_ok)
      mem[load_addr[AW-1:0]] <= load_data;
    else if (proc_w && hit_ram)
      mem[proc_addr[AW-1:0]] <= proc_dout;
    if (push_fire)
      fifo_mem[wr_ptr] <= proc_dout;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      proc_din <= 32'd0;
      bus_err  <= 1'b0;
      led      <= 32'd0;
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      count    <= '0;
      overflow <= 1'b0;
    end else begin
      proc_din <= rd_data;
      bus_err  <= unmapped;
      if (proc_w && hit_led)
        led <= proc_dout;
      if (overflow_set)
        overflow <= 1'b1;
      else if (proc_w && hit_status && proc_dout[0])
        overflow <= 1'b0;
      if (push_fire)
        wr_ptr <= wr_ptr + FW'(1);
      if (pop_fire)
        rd_ptr <= rd_ptr + FW'(1);
      case ({push_fire, pop_fire})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

`ifdef MMIO_CYCLE_CNT_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      cycle_cnt <= 32'd0;
    else if (proc_w && hit_cnt)
      cycle_cnt <= proc_dout;
    else
      cycle_cnt <= cycle_cnt + 32'd1;
  end
`endif

endmodule

// File: tb/tb_mmio_bus_bridge.sv
// Scoreboard bench for mmio_bus_bridge: driver steps a queue/array reference model at each negedge, monitor compares after each posedge.
module tb_mmio_bus_bridge;
  localparam logic [31:0] FIFO_A = 32'h0000_1000;
  localparam logic [31:0] STAT_A = 32'h0000_1001;
  localparam logic [31:0] CNT_A  = 32'h0000_1002;
  localparam logic [31:0] LED_A  = 32'h0000_2000;
  localparam int          MDEP   = 256;
  localparam int          FDEP   = 8;

  logic        clk = 1'b0, rst_n = 1'b0;
  logic [31:0] proc_addr = '0, proc_dout = '0, load_addr = '0, load_data = '0;
  logic        proc_w = 1'b0, load_en = 1'b0, host_pop = 1'b0;
  logic [31:0] proc_din, host_data, led;
  logic        host_valid, fifo_full, bus_err;

  mmio_bus_bridge dut (
    .clk(clk), .rst_n(rst_n), .proc_addr(proc_addr), .proc_dout(proc_dout), .proc_w(proc_w),
    .proc_din(proc_din), .load_en(load_en), .load_addr(load_addr), .load_data(load_data),
    .host_pop(host_pop), .host_data(host_data), .host_valid(host_valid), .fifo_full(fifo_full),
    .led(led), .bus_err(bus_err)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] din;
    logic        err;
    logic        valid;
    logic [31:0] hdata;
    logic        full;
    logic [31:0] led;
  } exp_t;

  exp_t        exp_q[$];
  exp_t        mon_e;
  logic [31:0] m_mem [MDEP];
  logic [31:0] m_fifo[$];
  logic        m_ovf = 1'b0;
  logic [31:0] m_led = '0;
  logic [31:0] m_cnt = '0;
  int          n_pass = 0, n_total = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    n_total++;
    if (act === req) n_pass++;
    else $display("FAIL %s: got %h, required %h (t=%0t)", name, act, req, $time);
  endtask

  // One bus cycle: drive at negedge, predict what the next posedge must produce.
  task automatic cyc(input logic [31:0] a, input logic w, input logic [31:0] d,
                     input logic le, input logic [31:0] la, input logic [31:0] ld, input logic pop);
    exp_t        e;
    logic [31:0] rd;
    int          sz;
    logic        pop_ok;
    @(negedge clk);
    rst_n = 1'b1;
    proc_addr = a; proc_w = w; proc_dout = d;
    load_en = le; load_addr = la; load_data = ld; host_pop = pop;

    sz = m_fifo.size();
    rd = 32'd0;
    e.err = 1'b0;
    if (a < MDEP)         rd = m_mem[a[7:0]];
    else if (a == FIFO_A) rd = (sz > 0) ? m_fifo[0] : 32'd0;
    else if (a == STAT_A) rd = (32'(sz) << 8) | (32'(m_ovf) << 2) | (32'(sz == FDEP) << 1) | 32'(sz == 0);
    else if (a == LED_A)  rd = m_led;
`ifdef MMIO_CYCLE_CNT_EN
    else if (a == CNT_A)  rd = m_cnt;
`endif
    else                  e.err = 1'b1;
    e.din = rd;

    if (le && la < MDEP)      m_mem[la[7:0]] = ld;
    else if (w && a < MDEP)   m_mem[a[7:0]] = d;
    if (w && a == LED_A)      m_led = d;
    if (w && a == STAT_A && d[0]) m_ovf = 1'b0;
    pop_ok = pop && (sz > 0);
    if (pop_ok) m_fifo.delete(0);
    if (w && a == FIFO_A) begin
      if (sz < FDEP || pop_ok) m_fifo.push_back(d);
      else                     m_ovf = 1'b1;
    end
`ifdef MMIO_CYCLE_CNT_EN
    if (w && a == CNT_A) m_cnt = d;
    else                 m_cnt = m_cnt + 32'd1;
`endif

    e.valid = (m_fifo.size() != 0);
    e.hdata = e.valid ? m_fifo[0] : 32'd0;
    e.full  = (m_fifo.size() == FDEP);
    e.led   = m_led;
    exp_q.push_back(e);
  endtask

  task automatic rd(input logic [31:0] a);
    cyc(a, 1'b0, 32'd0, 1'b0, 32'd0, 32'd0, 1'b0);
  endtask
  task automatic wr(input logic [31:0] a, input logic [31:0] d);
    cyc(a, 1'b1, d, 1'b0, 32'd0, 32'd0, 1'b0);
  endtask
  task automatic ld(input logic [31:0] la, input logic [31:0] ld_d);
    cyc(LED_A, 1'b0, 32'd0, 1'b1, la, ld_d, 1'b0);
  endtask
  task automatic pop1();
    cyc(LED_A, 1'b0, 32'd0, 1'b0, 32'd0, 32'd0, 1'b1);
  endtask

  // Reset is applied while a FIFO push is being presented; that push must not survive.
  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0;
    proc_addr = FIFO_A; proc_w = 1'b1; proc_dout = 32'h0000_0BAD;
    load_en = 1'b0; host_pop = 1'b0;
    #1;
    chk("rst_proc_din", proc_din, 32'd0);
    chk("rst_bus_err", {31'd0, bus_err}, 32'd0);
    chk("rst_led", led, 32'd0);
    chk("rst_host_valid", {31'd0, host_valid}, 32'd0);
    chk("rst_fifo_full", {31'd0, fifo_full}, 32'd0);
    chk("rst_host_data", host_data, 32'd0);
    m_fifo.delete();
    m_ovf = 1'b0; m_led = 32'd0; m_cnt = 32'd0;
    @(negedge clk);
  endtask

  initial begin
    forever begin
      @(posedge clk);
      #1;
      if (exp_q.size() > 0) begin
        mon_e = exp_q.pop_front();
        chk("proc_din", proc_din, mon_e.din);
        chk("bus_err", {31'd0, bus_err}, {31'd0, mon_e.err});
        chk("host_valid", {31'd0, host_valid}, {31'd0, mon_e.valid});
        chk("host_data", host_data, mon_e.hdata);
        chk("fifo_full", {31'd0, fifo_full}, {31'd0, mon_e.full});
        chk("led", led, mon_e.led);
      end
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation still running, required $finish");
    $fatal(1, "timeout");
  end

  initial begin
    logic [31:0] a, d, la;
    logic        w, le, p;
    do_reset();

    for (int i = 0; i < MDEP; i++) ld(32'(i), $urandom);

    ld(32'd5, 32'hDEAD_BEEF);
    rd(32'd5);
    rd(LED_A);

    for (int i = 1; i <= 9; i++) wr(FIFO_A, 32'(i));
    rd(STAT_A);
    rd(FIFO_A);
    wr(STAT_A, 32'd1);
    rd(STAT_A);

    for (int i = 0; i < 10; i++) pop1();
    rd(FIFO_A);
    rd(STAT_A);

    for (int i = 0; i < FDEP; i++) wr(FIFO_A, 32'h100 + 32'(i));
    cyc(FIFO_A, 1'b1, 32'h0000_0099, 1'b0, 32'd0, 32'd0, 1'b1);
    rd(STAT_A);
    for (int i = 0; i < FDEP; i++) pop1();

    cyc(32'd3, 1'b1, 32'hBBBB_BBBB, 1'b1, 32'd3, 32'hAAAA_AAAA, 1'b0);
    rd(32'd3);
    ld(32'h0000_0400, 32'h1234_5678);
    rd(32'd0);

    rd(32'h0000_3000);
    rd(LED_A);
    wr(32'h0000_3000, 32'hFFFF_FFFF);
    wr(LED_A, 32'h55);
    rd(LED_A);
    wr(CNT_A, 32'hFFFF_FFFE);
    rd(CNT_A);
    rd(CNT_A);
    rd(CNT_A);

    for (int i = 0; i <= FDEP; i++) wr(FIFO_A, 32'hF00 + 32'(i));
    rd(STAT_A);
    do_reset();
    rd(STAT_A);
    rd(LED_A);
    rd(FIFO_A);

    for (int i = 0; i < 3000; i++) begin
      if (i == 1000 || i == 2000) do_reset();
      case ($urandom_range(0, 9))
        0, 1, 2, 3: a = 32'($urandom_range(0, MDEP - 1));
        4, 5:       a = FIFO_A;
        6:          a = STAT_A;
        7:          a = LED_A;
        8:          a = CNT_A;
        default:    a = $urandom;
      endcase
      w  = 1'($urandom_range(0, 1));
      d  = $urandom;
      le = ($urandom_range(0, 3) == 0);
      la = ($urandom_range(0, 7) == 0) ? 32'(MDEP) + 32'($urandom_range(0, 1000)) : 32'($urandom_range(0, MDEP - 1));
      if (le && la >= MDEP && w && a < MDEP) la = 32'($urandom_range(0, MDEP - 1));
      p  = (i < 1500) ? ($urandom_range(0, 7) == 0) : ($urandom_range(0, 1) == 1);
      cyc(a, w, d, le, la, $urandom, p);
    end

    @(posedge clk);
    #2;
    chk("scoreboard_drained", 32'(exp_q.size()), 32'd0);
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
